// File: rtl/itf_multi_channel_pipe_if.sv
// Handshake bundle for itf_multi_channel_pipe: integer input side, float output side.
// Build option ITF_INEXACT_EN adds the per-channel inexact flags.
interface itf_multi_channel_pipe_if #(
   parameter int NUM_CH = 3,
   parameter int INT_W  = 32
);
   logic                    in_valid;
   logic                    in_ready;
   logic [NUM_CH*INT_W-1:0] int_in;
   logic                    signed_mode;
   logic                    out_valid;
   logic                    out_ready;
   logic [NUM_CH*32-1:0]    float_out;
   logic                    busy;
`ifdef ITF_INEXACT_EN
   logic [NUM_CH-1:0]       inexact;

   modport master (
      output in_valid, int_in, signed_mode, out_ready,
      input  in_ready, out_valid, float_out, busy, inexact
   );
   modport slave (
      input  in_valid, int_in, signed_mode, out_ready,
      output in_ready, out_valid, float_out, busy, inexact
   );
`else
   modport master (
      output in_valid, int_in, signed_mode, out_ready,
      input  in_ready, out_valid, float_out, busy
   );
   modport slave (
      input  in_valid, int_in, signed_mode, out_ready,
      output in_ready, out_valid, float_out, busy
   );
`endif
endinterface

// File: rtl/itf_multi_channel_pipe.sv
// N-channel integer -> IEEE-754 binary32 converter, 3-stage valid/ready pipeline, RNE rounding.
// Build option ITF_INEXACT_EN adds a registered per-channel inexact flag.
module itf_multi_channel_pipe #(
   parameter int NUM_CH = 3,
   parameter int INT_W  = 32
) (
   input logic                     clk,
   input logic                     clear,
   itf_multi_channel_pipe_if.slave bus
);
   localparam int POS_W = $clog2(INT_W);
   localparam int FW    = INT_W + 24;

   logic v1, v2, v3;
   logic rdy1, rdy2, rdy3;
   logic en1, en2, en3;

   // Valid/ready: a transfer happens on a stage boundary when the upstream valid and
   // the downstream ready are both 1 at the clock edge; an empty stage is always ready,
   // so bubbles collapse even while the output is stalled.
   assign rdy3 = !v3 | bus.out_ready;
   assign rdy2 = !v2 | rdy3;
   assign rdy1 = !v1 | rdy2;
   assign en1  = rdy1 & bus.in_valid;
   assign en2  = rdy2 & v1;
   assign en3  = rdy3 & v2;

   assign bus.in_ready  = rdy1;
   assign bus.out_valid = v3;
   assign bus.busy      = v1 | v2 | v3;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (rdy1) v1 <= bus.in_valid;
         if (rdy2) v2 <= v1;
         if (rdy3) v3 <= v2;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [INT_W-1:0] x, mag_d, mag1, norm_d, norm2;
      logic             sign_d, sign1, sign2;
      logic [POS_W-1:0] pos_d, pos2;
      logic [FW-1:0]    frac;
      logic [22:0]      mant;
      logic             guard, sticky, rnd, nonzero;
      logic [7:0]       expo;
      logic [30:0]      body;
      logic [31:0]      float_d, float3;

      assign x      = bus.int_in[k*INT_W +: INT_W];
      assign sign_d = bus.signed_mode & x[INT_W-1];
      assign mag_d  = sign_d ? -x : x;

      always_comb begin
         pos_d = '0;
         for (int i = 0; i < INT_W; i++) begin
            if (mag1[i]) pos_d = POS_W'(i);
         end
      end
      assign norm_d = mag1 << (POS_W'(INT_W - 1) - pos_d);

      // After normalisation the MSB is the leading one, so it doubles as the non-zero flag.
      assign nonzero = norm2[INT_W-1];
      assign frac    = {norm2[INT_W-2:0], 25'd0};
      assign mant    = frac[FW-1 -: 23];
      assign guard   = frac[FW-24];
      assign sticky  = |frac[FW-25:0];
      assign rnd     = guard & (sticky | mant[0]);
      assign expo    = 8'd127 + 8'(pos2);
      // Mantissa carry ripples straight into the exponent field.
      assign body    = {expo, mant} + {30'd0, rnd};
      assign float_d = nonzero ? {sign2, body} : 32'd0;

      always_ff @(posedge clk or negedge clear) begin
         if (!clear) begin
            sign1  <= 1'b0;
            mag1   <= '0;
            sign2  <= 1'b0;
            pos2   <= '0;
            norm2  <= '0;
            float3 <= '0;
         end else begin
            if (en1) begin
               sign1 <= sign_d;
               mag1  <= mag_d;
            end
            if (en2) begin
               sign2 <= sign1;
               pos2  <= pos_d;
               norm2 <= norm_d;
            end
            if (en3) float3 <= float_d;
         end
      end
      assign bus.float_out[k*32 +: 32] = float3;

`ifdef ITF_INEXACT_EN
      logic inex3;
      always_ff @(posedge clk or negedge clear) begin
         if (!clear)   inex3 <= 1'b0;
         else if (en3) inex3 <= nonzero & (guard | sticky);
      end
      assign bus.inexact[k] = inex3;
`endif
   end
endmodule

// File: tb/tb_itf_multi_channel_pipe.sv
// Self-checking bench for itf_multi_channel_pipe (NUM_CH=3, INT_W=32) with a scoreboard queue.
// Honours ITF_INEXACT_EN when defined.
module tb_itf_multi_channel_pipe;
   localparam int NUM_CH = 3;
   localparam int INT_W  = 32;
   localparam int W      = NUM_CH * 32;

   logic clk = 1'b0;
   logic clear;

   itf_multi_channel_pipe_if #(.NUM_CH(NUM_CH), .INT_W(INT_W)) bus ();

   itf_multi_channel_pipe #(.NUM_CH(NUM_CH), .INT_W(INT_W)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int failures  = 0;
   int accepted  = 0;
   int occ       = 0;
   int rdy_mode  = 0;
   bit mon_en    = 1'b0;
   bit stall_prev = 1'b0;
   logic [W-1:0] held_f;
   logic [W-1:0] exp_q[$];
   logic [NUM_CH-1:0] exp_x_q[$];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Independent reference: integer shift-and-compare rounding on a 64-bit magnitude.
   function automatic logic [31:0] ref_conv(input logic [31:0] x, input logic sm, output logic inex);
      logic s;
      logic [63:0] mag, m, rem, half;
      int e, sh;
      s = sm & x[31];
      mag = s ? (64'd4294967296 - {32'd0, x}) : {32'd0, x};
      inex = 1'b0;
      if (mag == 64'd0) return 32'd0;
      e = 31;
      while (mag[e] == 1'b0) e--;
      if (e <= 23) begin
         m = mag << (23 - e);
      end else begin
         sh = e - 23;
         m = mag >> sh;
         rem = mag & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         inex = (rem != 64'd0);
         if (rem > half || (rem == half && m[0])) m = m + 64'd1;
         if (m[24]) begin
            m = m >> 1;
            e++;
         end
      end
      return {s, 8'(e + 127), m[22:0]};
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      case ($urandom_range(0, 4))
         0:       w = $urandom;
         1:       w = 32'd0;
         2:       w = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         3:       w = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
         default: w = 32'($urandom_range(0, 300));
      endcase
      return w;
   endfunction

   // out_ready pattern: 0 always high, 1 always low, 2 toggling, 3 random.
   always @(negedge clk) begin
      case (rdy_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = 1'b0;
         2:       bus.out_ready = !bus.out_ready;
         default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic send_exp(input logic [W-1:0] d, input logic sm,
                           input logic [W-1:0] ef, input logic [NUM_CH-1:0] ex);
      int n;
      n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.int_in = d;
      bus.signed_mode = sm;
      #1;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!bus.in_ready) begin
         check("send_timeout", 1, 0);
      end else begin
         exp_q.push_back(ef);
         exp_x_q.push_back(ex);
         accepted++;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic send_model(input logic [W-1:0] d, input logic sm);
      logic [W-1:0] ef;
      logic [NUM_CH-1:0] ex;
      logic b;
      for (int k = 0; k < NUM_CH; k++) begin
         ef[k*32 +: 32] = ref_conv(d[k*32 +: 32], sm, b);
         ex[k] = b;
      end
      send_exp(d, sm, ef, ex);
   endtask

   task automatic send_rand();
      logic [W-1:0] d;
      for (int k = 0; k < NUM_CH; k++) d[k*32 +: 32] = rnd_word();
      send_model(d, 1'($urandom_range(0, 1)));
   endtask

   task automatic latency_probe(input logic [W-1:0] d, input logic sm);
      int cyc;
      cyc = 1;
      send_model(d, sm);
      @(negedge clk);
      #3;
      while (!bus.out_valid && cyc < 20) begin
         @(negedge clk);
         #3;
         cyc++;
      end
      check("latency", cyc, 3);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   // Monitor: scoreboard pop, stall stability and occupancy-based ready/busy checks.
   always @(negedge clk) begin
      logic [W-1:0] ef;
      logic [NUM_CH-1:0] ex;
      #2;
      if (mon_en) begin
         check("in_ready_occ", bus.in_ready, (occ < 3) || bus.out_ready);
         check("busy_occ", bus.busy, occ != 0);
         if (stall_prev) begin
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.float_out, held_f);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               ef = exp_q.pop_front();
               ex = exp_x_q.pop_front();
               check("data", bus.float_out, ef);
`ifdef ITF_INEXACT_EN
               check("inexact", bus.inexact, ex);
`endif
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         held_f = bus.float_out;
         occ = occ + int'(bus.in_valid && bus.in_ready) - int'(bus.out_valid && bus.out_ready);
      end
   end

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL global_timeout got=%0d exp=0", exp_q.size());
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.int_in = '0;
      bus.signed_mode = 1'b0;
      bus.out_ready = 1'b1;
      #13;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_float", bus.float_out, 0);
      check("rst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      #5 clear = 1'b1;
      mon_en = 1'b1;

      // Directed conversions, including first-item latency.
      latency_probe({32'd0, 32'd255, 32'd1}, 1'b0);
      send_exp({32'd0, 32'd255, 32'd1}, 1'b0, {32'h0000_0000, 32'h437F_0000, 32'h3F80_0000}, 3'b000);
      send_exp({32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF}, 1'b1,
               {32'h4F00_0000, 32'hCF00_0000, 32'hBF80_0000}, 3'b100);
      send_exp({32'hFFFF_FFFF, 32'd16777219, 32'd16777217}, 1'b0,
               {32'h4F80_0000, 32'h4B80_0002, 32'h4B80_0000}, 3'b111);
      drain();

      // Backpressure: six items against a stalled output.
      rdy_mode = 1;
      repeat (2) @(negedge clk);
      base = accepted;
      fork
         begin
            for (int i = 1; i <= 6; i++)
               send_model({32'(i * 1000), 32'(i * 100), 32'(i)}, 1'b0);
         end
      join_none
      repeat (8) @(negedge clk);
      #3;
      check("stall_accepted", accepted - base, 3);
      check("stall_in_ready", bus.in_ready, 0);
      rdy_mode = 0;
      wait fork;
      drain();

      // Bubbles: gapped stimulus, toggling output ready.
      rdy_mode = 2;
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send_rand();
      end
      drain();

      // Random backpressure, back-to-back input.
      rdy_mode = 3;
      for (int i = 0; i < 40; i++) send_rand();
      rdy_mode = 0;
      drain();

      // Asynchronous clear with items in flight.
      rdy_mode = 1;
      @(negedge clk);
      send_rand();
      send_rand();
      repeat (3) @(negedge clk);
      #5;
      check("pre_clear_valid", bus.out_valid, 1);
      check("pre_clear_busy", bus.busy, 1);
      mon_en = 1'b0;
      clear = 1'b0;
      #1;
      check("clear_out_valid", bus.out_valid, 0);
      check("clear_busy", bus.busy, 0);
      check("clear_float", bus.float_out, 0);
      check("clear_in_ready", bus.in_ready, 1);
      exp_q.delete();
      exp_x_q.delete();
      occ = 0;
      stall_prev = 1'b0;
      @(negedge clk);
      #5 clear = 1'b1;
      rdy_mode = 0;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      latency_probe({32'd7, 32'h8000_0001, 32'hFFFF_FF00}, 1'b1);
      drain();

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
